// File: rtl/dff_arb_pkg.sv
// Shared types and helpers for the round-robin D-register bank arbiter.
package dff_arb_pkg;

  localparam int unsigned MAX_REQ = 32;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  // Wide one-hot; callers truncate to their own requester count.
  function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
    return MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/dff_bank_arbiter_rr_picker.sv
// Combinational round-robin winner selection starting at rr_ptr.
module rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [PTR_W-1:0]   winner,
  output logic               any_req
);

  localparam int unsigned IDX_W = (2 * NUM_REQ > 2) ? $clog2(2 * NUM_REQ) : 1;

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;

  // Rotate via the doubled vector, then take the lowest set bit of the rotation.
  always_comb begin
    dbl     = {req, req};
    rot     = '0;
    winner  = '0;
    any_req = |req;
    for (int i = 0; i < NUM_REQ; i++) begin
      rot[i] = dbl[IDX_W'(rr_ptr) + IDX_W'(i)];
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) winner = PTR_W'((32'(rr_ptr) + 32'(i)) % NUM_REQ);
    end
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter sharing one DATA_W register among NUM_REQ writers, with capped locked bursts.
module dff_bank_arbiter
  import dff_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         q,
  output logic                      q_valid,
  output logic                      busy
);

  localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [DATA_W-1:0]   q_q, q_d;
  logic                qv_q, qv_d;
  logic                busy_q, busy_d;
  logic [PTR_W-1:0]    rr_q, rr_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;

  logic [PTR_W-1:0]    winner;
  logic                any_req;
  logic                req_own, lock_own, xfer, release_own;
  logic [DATA_W-1:0]   wdata_own;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req     (req),
    .rr_ptr  (rr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  // Select the current owner's request, lock and data slice.
  always_comb begin
    req_own   = 1'b0;
    lock_own  = 1'b0;
    wdata_own = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == PTR_W'(i)) begin
        req_own   = req[i];
        lock_own  = lock[i];
        wdata_own = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    ack_d       = '0;
    q_d         = q_q;
    qv_d        = 1'b0;
    rr_d        = rr_q;
    owner_d     = owner_q;
    hold_d      = hold_q;
    xfer        = 1'b0;
    release_own = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = OWN;
          gnt_d   = NUM_REQ'(onehot(32'(winner)));
          owner_d = winner;
          hold_d  = '0;
        end
      end
      OWN: begin
        xfer = req_own;
        if (xfer) begin
          q_d    = wdata_own;
          ack_d  = NUM_REQ'(onehot(32'(owner_q)));
          qv_d   = 1'b1;
          hold_d = hold_q + HOLD_W'(1);
        end
        // The cap counts the capture happening at this edge.
        release_own = !lock_own || !req_own || (xfer && hold_q == HOLD_W'(MAX_HOLD - 1));
        if (release_own) begin
          state_d = IDLE;
          gnt_d   = '0;
          rr_d    = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
    busy_d = (state_d == OWN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      q_q     <= '0;
      qv_q    <= 1'b0;
      busy_q  <= 1'b0;
      rr_q    <= '0;
      owner_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      q_q     <= q_d;
      qv_q    <= qv_d;
      busy_q  <= busy_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt     = gnt_q;
  assign ack     = ack_q;
  assign q       = q_q;
  assign q_valid = qv_q;
  assign busy    = busy_q;

endmodule
